// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded grant hold time.
// One dead cycle separates every release from the next grant.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] id_q, id_d;
    logic       valid_q, valid_d;
    logic       to_q, to_d;
    logic [7:0] gnt_q, gnt_d;

    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  pick_off;
    logic [2:0]  pick;

    // Rotate requests so that the pointer position lands on bit 0.
    always_comb begin
        req_dbl  = {req, req} >> ptr_q;
        req_rot  = req_dbl[7:0];
        pick_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_off = 3'(i);
            end
        end
        pick = ptr_q + pick_off;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        id_d    = id_q;
        valid_d = valid_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                hold_d  = 8'd0;
                if (en && (req != 8'd0)) begin
                    state_d = GRANT;
                    id_d    = pick;
                    valid_d = 1'b1;
                    hold_d  = 8'd1;
                end
            end
            GRANT: begin
                if (!req[id_q] || (hold_q == 8'(MAX_HOLD))) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    hold_d  = 8'd0;
                    ptr_d   = id_q + 3'd1;
                    to_d    = req[id_q];
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
        endcase
        gnt_d = valid_d ? (8'd1 << id_d) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            hold_q  <= 8'd0;
            id_q    <= 3'd0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            gnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            to_q    <= to_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = valid_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: behavioural model checked every cycle
// plus directed scenarios with literal expected grants.
module tb_rr_arbiter8;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] req = 8'd0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .req(req),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who holds the grant, for how long, and whose turn it is.
    bit m_v;
    int m_id;
    int m_ptr;
    int m_cnt;
    bit m_to;

    always @(posedge clk) begin
        if (rst) begin
            m_v = 0; m_id = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (!m_v) begin
                if (en && req != 8'd0) begin
                    bit found;
                    found = 0;
                    for (int k = 0; k < 8; k++) begin
                        if (!found && req[(m_ptr + k) % 8]) begin
                            m_id  = (m_ptr + k) % 8;
                            found = 1;
                        end
                    end
                    m_v = 1;
                    m_cnt = 1;
                end
            end else if (!req[m_id] || m_cnt == MH) begin
                m_to  = req[m_id];
                m_v   = 0;
                m_ptr = (m_id + 1) % 8;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic [7:0] eg;
            eg = m_v ? (8'd1 << m_id) : 8'd0;
            chk("model_gnt", gnt, eg);
            chk("model_valid", gnt_valid, m_v);
            chk("model_timeout", timeout, m_to);
            if (m_v) chk("model_id", gnt_id, m_id);
            chk("onehot", $onehot0(gnt), 1);
            if (gnt_valid) chk("decode", gnt, 8'd1 << gnt_id);
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [7:0] q);
        rst = r;
        en  = e;
        req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_g(input string nm, input logic [7:0] g,
                            input logic t);
        chk({nm, "_gnt"}, gnt, g);
        chk({nm, "_to"}, timeout, t);
    endtask

    initial begin
        // reset overrides active requests
        cyc(1, 1, 8'hFF);
        started = 1'b1;
        expect_g("reset", 8'h00, 0);
        chk("reset_id", gnt_id, 0);
        chk("reset_valid", gnt_valid, 0);

        // lowest index wins from ptr=0, then the next in line after a gap
        cyc(0, 1, 8'h05);
        expect_g("s28_g0", 8'h01, 0);
        chk("s28_id0", gnt_id, 0);
        cyc(0, 1, 8'h04);
        expect_g("s28_dead", 8'h00, 0);
        chk("s28_id_kept", gnt_id, 0);
        cyc(0, 1, 8'h04);
        expect_g("s28_g2", 8'h04, 0);
        cyc(0, 1, 8'h00);
        expect_g("s28_rel", 8'h00, 0);

        // full rotation with a dead cycle between each grant
        cyc(1, 0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            logic [7:0] b;
            b = 8'd1 << (i % 8);
            cyc(0, 1, 8'hFF);
            expect_g($sformatf("rot%0d", i), b, 0);
            cyc(0, 1, 8'hFF & ~b);
            expect_g($sformatf("rot%0d_dead", i), 8'h00, 0);
        end
        cyc(0, 1, 8'h00);

        // hold limit: four grant cycles, a timeout gap, then regrant
        cyc(1, 0, 8'h00);
        for (int i = 0; i < MH; i++) begin
            cyc(0, 1, 8'h08);
            expect_g($sformatf("hold%0d", i), 8'h08, 0);
        end
        cyc(0, 1, 8'h08);
        expect_g("forced", 8'h00, 1);
        cyc(0, 1, 8'h08);
        expect_g("regrant", 8'h08, 0);
        cyc(0, 1, 8'h00);
        expect_g("hold_rel", 8'h00, 0);

        // enable gates only new grants
        cyc(0, 0, 8'h10);
        expect_g("en_off0", 8'h00, 0);
        cyc(0, 0, 8'h10);
        expect_g("en_off1", 8'h00, 0);
        cyc(0, 1, 8'h10);
        expect_g("en_on", 8'h10, 0);
        cyc(0, 0, 8'h10);
        expect_g("en_drop0", 8'h10, 0);
        cyc(0, 0, 8'h1F);
        expect_g("en_drop1", 8'h10, 0);
        cyc(0, 0, 8'h0F);
        expect_g("en_rel", 8'h00, 0);

        // reset during a grant to 7 drops it silently
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h80);
        expect_g("g7", 8'h80, 0);
        chk("g7_id", gnt_id, 7);
        cyc(1, 1, 8'h80);
        expect_g("rst_mid", 8'h00, 0);
        chk("rst_mid_id", gnt_id, 0);
        cyc(0, 1, 8'h81);
        expect_g("post_rst", 8'h01, 0);

        // pointer wrap after releasing 7
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h80);
        cyc(0, 1, 8'h01);
        expect_g("wrap_dead", 8'h00, 0);
        cyc(0, 1, 8'h81);
        expect_g("wrap_g0", 8'h01, 0);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
